pd_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one PATTERN detector datapath between N_CH serial bit streams.
//  - Each cycle, grants one requesting channel and consumes one bit from it.
//  - Keeps per-channel detection context (bit history + fill count) so streams never interfere.
//  - Emits one registered result per consumed bit.
//  - Sits between the per-lane serial receivers and the match-event logic.

---
 rtl/pd_pkg.sv | 18 +
 rtl/pd_step.sv | 21 ++
 rtl/pd_rr_sched.sv | 108 ++++++++++
 tb/tb_pd_rr_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - shared pattern-detector constants, context type and width helper
package pd_pkg;

    localparam int PAT_W = 6;
    localparam logic [PAT_W-1:0] PATTERN = 6'b110110;
    localparam int FCNT_W = $clog2(PAT_W + 1);

    typedef struct packed {
        logic [PAT_W-1:0]  hist;
        logic [FCNT_W-1:0] fcnt;
    } pd_ctx_t;

    // A single-channel build still needs a 1-bit channel index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pd_step.sv
// rtl/pd_step.sv - combinational one-bit step of the shared pattern detector
module pd_step
    import pd_pkg::*;
(
    input  pd_ctx_t ctx_i,
    input  logic    bit_i,
    output pd_ctx_t ctx_o,
    output logic    match_o
);

    always_comb begin
        ctx_o      = ctx_i;
        ctx_o.hist = {ctx_i.hist[PAT_W-2:0], bit_i};
        if (ctx_i.fcnt != FCNT_W'(PAT_W)) begin
            ctx_o.fcnt = ctx_i.fcnt + FCNT_W'(1);
        end
        // A full window is required so zero-filled history never fakes a match.
        match_o = (ctx_o.hist == PATTERN) && (ctx_o.fcnt == FCNT_W'(PAT_W));
    end

endmodule

// File: rtl/pd_rr_sched.sv
// rtl/pd_rr_sched.sv - round-robin scheduler sharing one pattern detector; optional counters via PD_RR_SCHED_MATCH_CNT_EN
module pd_rr_sched
    import pd_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [N_CH-1:0]       req_valid_i,
    input  logic [N_CH-1:0]       req_data_i,
    output logic [N_CH-1:0]       req_ready_o,
    output logic                  pd_valid_o,
    output logic [ch_w(N_CH)-1:0] pd_ch_o,
    output logic                  pd_o
`ifdef PD_RR_SCHED_MATCH_CNT_EN
    ,
    output logic [N_CH*16-1:0]    match_cnt_o
`endif
);

    localparam int CH_W = ch_w(N_CH);

    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] gnt_idx;
    logic            found;
    logic            xfer;
    pd_ctx_t         ctx_q [N_CH];
    pd_ctx_t         step_ctx;
    logic            step_match;

    // Search starts just after the last winner so every requester is reached within N_CH grants.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!found && req_valid_i[(int'(rr_ptr_q) + k) % N_CH]) begin
                found   = 1'b1;
                gnt_idx = CH_W'((int'(rr_ptr_q) + k) % N_CH);
            end
        end
    end

    assign xfer = found & ~flush_i & rst_ni;

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    pd_step u_step (
        .ctx_i   (ctx_q[gnt_idx]),
        .bit_i   (req_data_i[gnt_idx]),
        .ctx_o   (step_ctx),
        .match_o (step_match)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) begin
                ctx_q[c] <= '0;
            end
            rr_ptr_q   <= CH_W'(N_CH - 1);
            pd_valid_o <= 1'b0;
            pd_o       <= 1'b0;
            pd_ch_o    <= '0;
        end else begin
            pd_valid_o <= xfer;
            pd_o       <= xfer & step_match;
            if (xfer) begin
                pd_ch_o  <= gnt_idx;
                rr_ptr_q <= gnt_idx;
            end
            if (flush_i) begin
                for (int c = 0; c < N_CH; c++) begin
                    ctx_q[c] <= '0;
                end
            end else if (xfer) begin
                ctx_q[gnt_idx] <= step_ctx;
            end
        end
    end

`ifdef PD_RR_SCHED_MATCH_CNT_EN
    logic [15:0] cnt_q [N_CH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else if (flush_i) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else if (xfer && step_match && (cnt_q[gnt_idx] != 16'hFFFF)) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 16'd1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign match_cnt_o[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_pd_rr_sched.sv
// tb/tb_pd_rr_sched.sv - scoreboard bench for pd_rr_sched with hand-computed vectors
module tb_pd_rr_sched;

    localparam int N_CH = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic [N_CH-1:0] req_valid_i = '0;
    logic [N_CH-1:0] req_data_i = '0;
    logic [N_CH-1:0] req_ready_o;
    logic            pd_valid_o;
    logic [1:0]      pd_ch_o;
    logic            pd_o;
`ifdef PD_RR_SCHED_MATCH_CNT_EN
    logic [N_CH*16-1:0] match_cnt_o;
`endif

    int checks = 0;
    int failures = 0;
    int exp_ch_q[$];
    bit exp_m_q[$];

    pd_rr_sched #(.N_CH(N_CH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .pd_valid_o  (pd_valid_o),
        .pd_ch_o     (pd_ch_o),
        .pd_o        (pd_o)
`ifdef PD_RR_SCHED_MATCH_CNT_EN
        ,
        .match_cnt_o (match_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding accepted bit.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (pd_valid_o) begin
                if (exp_ch_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got ch=%0d pd=%0b expected none", pd_ch_o, pd_o);
                end else begin
                    chk("result_ch", 64'(pd_ch_o), 64'(exp_ch_q.pop_front()));
                    chk("result_pd", 64'(pd_o), 64'(exp_m_q.pop_front()));
                end
            end else begin
                chk("idle_pd", 64'(pd_o), 64'd0);
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid_i = '0;
        flush_i = 1'b0;
        @(negedge clk_i);
        exp_ch_q.delete();
        exp_m_q.delete();
        rst_ni = 1'b1;
    endtask

    // Offers n bits MSB-first on one channel; exp holds the hand-computed match per bit.
    task automatic send_seq(input int ch, input logic [15:0] bits, input int n, input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            int waitc = 0;
            req_valid_i = '0;
            req_valid_i[ch] = 1'b1;
            req_data_i[ch] = bits[n-1-i];
            #1;
            while (!req_ready_o[ch] && waitc < 20) begin
                @(negedge clk_i);
                #1;
                waitc++;
            end
            if (!req_ready_o[ch]) begin
                checks++;
                failures++;
                $display("FAIL grant_timeout: got ready=%0b expected ch %0d granted", req_ready_o, ch);
            end else begin
                exp_ch_q.push_back(ch);
                exp_m_q.push_back(exp[n-1-i]);
            end
            @(negedge clk_i);
        end
        req_valid_i = '0;
    endtask

    initial begin
        logic [5:0] pat;
        pat = 6'b110110;

        @(negedge clk_i);
        #1;
        chk("reset_valid", 64'(pd_valid_o), 64'd0);
        chk("reset_pd", 64'(pd_o), 64'd0);
        chk("reset_ch", 64'(pd_ch_o), 64'd0);
        chk("reset_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        send_seq(0, 16'b110110, 6, 16'b000001);
        send_seq(1, 16'b11011011011, 11, 16'b00000100100);

        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N_CH; k++) begin
                req_valid_i = 4'hF;
                req_data_i = {4{pat[5-r]}};
                #1;
                chk("rr_grant", 64'(req_ready_o), 64'(4'b0001 << k));
                exp_ch_q.push_back(k);
                exp_m_q.push_back(r == 5);
                @(negedge clk_i);
            end
        end
        req_valid_i = '0;

        do_reset();
        send_seq(2, 16'b110, 3, 16'b000);
        flush_i = 1'b1;
        req_valid_i = 4'b0100;
        req_data_i[2] = 1'b1;
        #1;
        chk("flush_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        req_valid_i = '0;
        send_seq(2, 16'b110, 3, 16'b000);
        send_seq(2, 16'b110, 3, 16'b001);

        do_reset();
        send_seq(3, 16'b1101, 4, 16'b0000);
        req_valid_i[3] = 1'b1;
        #2;
        chk("pre_reset_valid", 64'(pd_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("async_valid", 64'(pd_valid_o), 64'd0);
        chk("async_pd", 64'(pd_o), 64'd0);
        chk("async_ch", 64'(pd_ch_o), 64'd0);
        chk("async_ready", 64'(req_ready_o), 64'd0);
        req_valid_i = '0;
        exp_ch_q.delete();
        exp_m_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_seq(3, 16'b10, 2, 16'b00);
        send_seq(3, 16'b110110, 6, 16'b000001);

`ifdef PD_RR_SCHED_MATCH_CNT_EN
        do_reset();
        send_seq(3, 16'b110110110110, 12, 16'b000001001001);
        @(negedge clk_i);
        chk("cnt_ch3", 64'(match_cnt_o[63:48]), 64'd3);
        chk("cnt_others", 64'(match_cnt_o[47:0]), 64'd0);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("cnt_flush", 64'(match_cnt_o), 64'd0);
`endif

        repeat (3) @(negedge clk_i);
        chk("queue_drained", 64'(exp_ch_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
